// File: rtl/divu_8by4_if.sv
`default_nettype none
// ============================================================================
// Module      : divu_8by4_if
// Description : Request/result bundle for the 8-by-4 unsigned divider.
//               master drives the operands and start; slave returns the
//               quotient, remainder and status.
// Signals     : start    - begin a division (sampled on rising clk)
//               a, b     - 8-bit dividend, 4-bit divisor
//               q, r     - 8-bit quotient, 4-bit remainder (held)
//               busy     - iteration in progress
//               done     - one-cycle result strobe
//               div_zero - accepted divisor was zero
// Revision    : 1.0  initial release
// ============================================================================
interface divu_8by4_if;
  logic       start;
  logic [7:0] a;
  logic [3:0] b;
  logic [7:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       div_zero;

  modport master (
    output start, a, b,
    input  q, r, busy, done, div_zero
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/divu_8by4.sv
`default_nettype none
// ============================================================================
// Module      : divu_8by4
// Description : Sequential restoring divider, 8-bit unsigned dividend by
//               4-bit unsigned divisor. One quotient bit per clock, result
//               8 clocks after the accepting edge. A zero divisor bypasses
//               the iteration and returns all-ones with div_zero set.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-low
//               bus   - divu_8by4_if.slave (start/a/b in, q/r/busy/done/
//                       div_zero out)
// Revision    : 1.0  initial release
// ============================================================================
module divu_8by4 (
  input  logic          clk,
  input  logic          reset,
  divu_8by4_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] c_last_step = 3'd7;

  logic [1:0] r_state;
  logic [1:0] w_next_state;

  logic [2:0] r_cnt;
  logic [7:0] r_dvd;      // dividend shifting out, quotient bits shifting in
  logic [3:0] r_dvs;
  logic [4:0] r_rem;      // partial remainder
  logic [7:0] r_q;
  logic [3:0] r_r;
  logic       r_dz;

  logic       w_accept;
  logic       w_last;
  logic       w_busy;
  logic       w_done;
  logic [4:0] w_shift;
  logic [5:0] w_trial;
  logic       w_ge;
  logic [4:0] w_rem_next;
  logic [7:0] w_dvd_next;

  // New work is only taken when not iterating; start during CALC is dropped.
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == c_last_step);

  // Restoring step. The trial subtraction is one bit wider than the shifted
  // remainder so its MSB is a clean borrow flag; r_rem[4] feeds that top bit
  // so the full shifted value takes part in the compare.
  assign w_shift    = {r_rem[3:0], r_dvd[7]};
  assign w_trial    = {r_rem[4], w_shift} - {2'b00, r_dvs};
  assign w_ge       = ~w_trial[5];
  assign w_rem_next = w_ge ? w_trial[4:0] : w_shift;
  assign w_dvd_next = {r_dvd[6:0], w_ge};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = (bus.b == 4'd0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_next_state = (bus.b == 4'd0) ? S_DONE : S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_CALC:  w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture, iteration and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 3'd0;
      r_dvd <= 8'h00;
      r_dvs <= 4'h0;
      r_rem <= 5'd0;
      r_q   <= 8'h00;
      r_r   <= 4'h0;
      r_dz  <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= bus.a;
      r_dvs <= bus.b;
      r_rem <= 5'd0;
      r_cnt <= 3'd0;
      // Zero divisor publishes its saturated result at the accepting edge.
      if (bus.b == 4'd0) begin
        r_q  <= 8'hFF;
        r_r  <= 4'hF;
        r_dz <= 1'b1;
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_next;
      r_dvd <= w_dvd_next;
      r_cnt <= r_cnt + 3'd1;
      if (w_last) begin
        r_q  <= w_dvd_next;
        r_r  <= w_rem_next[3:0];
        r_dz <= 1'b0;
      end
    end
  end

  assign bus.q        = r_q;
  assign bus.r        = r_r;
  assign bus.div_zero = r_dz;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;

endmodule
`default_nettype wire

// File: tb/tb_divu_8by4.sv
`default_nettype none
// ============================================================================
// Module      : tb_divu_8by4
// Description : Self-checking bench for divu_8by4. Expected results are
//               queued when an operation is launched and compared when the
//               divider strobes done.
// Revision    : 1.0  initial release
// ============================================================================
module tb_divu_8by4;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];
  logic [7:0] last_q;
  logic [3:0] last_r;

  divu_8by4_if bus ();

  divu_8by4 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [7:0] av, input logic [3:0] bv);
    exp_t e;
    if (bv == 4'd0) begin
      e.q = 8'hFF; e.r = 4'hF; e.dz = 1'b1;
    end else begin
      e.q  = av / {4'd0, bv};
      e.r  = 4'(av % {4'd0, bv});
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Result monitor: every done strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", 32'(bus.q), 32'(e.q));
        check("r", 32'(bus.r), 32'(e.r));
        check("div_zero", 32'(bus.div_zero), 32'(e.dz));
      end
    end
  end

  // Launch one operation (call just after a negedge). Counts negedges until
  // done, checks latency and busy width. glitch>0 re-pulses start with other
  // operands at that CALC cycle.
  task automatic do_op(input logic [7:0] av, input logic [3:0] bv, input int glitch);
    exp_t e;
    int   k;
    int   busy_n;
    bit   seen;
    e = model(av, bv);
    sb.push_back(e);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    busy_n    = 0;
    seen      = 1'b0;
    k         = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      bus.a     = 8'($urandom);
      bus.b     = 4'($urandom);
      bus.start = (k == glitch);
      if (k == glitch) begin
        check("hold_q_calc", 32'(bus.q), 32'(last_q));
        check("hold_r_calc", 32'(bus.r), 32'(last_r));
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(k - 1), (bv == 4'd0) ? 32'd0 : 32'd8);
    check("busy_cycles", 32'(busy_n), (bv == 4'd0) ? 32'd0 : 32'd8);
    last_q = e.q;
    last_r = e.r;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dn;
    int k;
    n_checks  = 0;
    n_errors  = 0;
    last_q    = 8'h00;
    last_r    = 4'h0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_r", 32'(bus.r), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dz", 32'(bus.div_zero), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed operations
    do_op(8'd20, 4'd5, 0);
    repeat (3) @(negedge clk);
    check("hold_q_idle", 32'(bus.q), 32'd4);
    check("hold_done_idle", 32'(bus.done), 32'd0);
    do_op(8'd225, 4'd15, 0);
    do_op(8'd255, 4'd1, 0);
    do_op(8'd20, 4'd7, 0);
    do_op(8'd0, 4'd9, 0);
    do_op(8'd200, 4'd0, 0);
    do_op(8'd100, 4'd9, 0);
    do_op(8'd20, 4'd7, 3);

    // Reset in the middle of CALC
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd200; bus.b = 4'd7;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_q", 32'(bus.q), 32'd0);
    check("arst_r", 32'(bus.r), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_dz", 32'(bus.div_zero), 32'd0);
    last_q = 8'h00;
    last_r = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_op(8'd20, 4'd5, 0);

    // start held high: back-to-back divisions every 9 clocks
    bus.start = 1'b1; bus.a = 8'd100; bus.b = 4'd3;
    for (int i = 0; i < 4; i++) sb.push_back(model(8'd100, 4'd3));
    dn = 0;
    k  = 0;
    while (dn < 4 && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.done === 1'b1) begin
        dn++;
        check("cont_period", 32'(k), 32'(9 * dn));
        if (dn == 4) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("cont_count", 32'(dn), 32'd4);
    last_q = 8'd33;
    last_r = 4'd1;

    // Exhaustive sweep against the reference model
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        do_op(8'(ai), 4'(bi), 0);
      end
    end
    repeat (3) @(negedge clk);
    check("final_hold_q", 32'(bus.q), 32'(last_q));
    check("final_idle_busy", 32'(bus.busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
